ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 npc_valid  in  1  commit stage presents the next PC (computed by the next-PC selector) for one cycle.
REQ-005 npc  in  32  next PC value; sampled only when npc_valid=1.
REQ-006 imem_arvalid  out  1  fetch address valid.
REQ-007 imem_araddr  out  32  fetch address; equals the current pc.
REQ-008 imem_arready  in  1  memory accepts the address.
REQ-009 imem_rvalid  in  1  read data valid.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 imem_rresp  in  2  response code; 2'b00 = OKAY.
REQ-012 imem_rready  out  1  fetch unit ready for read data.
REQ-013 inst_valid  out  1  instruction offered to the decoder.
REQ-014 inst  out  32  latched instruction word.
REQ-015 pc  out  32  PC of inst.
REQ-016 inst_ready  in  1  decoder accepts inst.
REQ-017 fetch_err  out  2  error flags qualified by inst_valid: bit0 = bus error, bit1 = misaligned PC.

Function
REQ-018 The FSM SHALL have states IDLE, AR, R, ISSUE and WAIT_NPC, with the state and all outputs held in registers.
REQ-019 IDLE SHALL transition unconditionally to AR on the next edge.
REQ-020 On entry to AR with pc[1:0]!=0, the FSM SHALL skip the bus, set fetch_err=2'b10, set inst=32'h0000_0013 and go to ISSUE.
REQ-021 In AR: imem_arvalid=1, imem_araddr=pc; imem_arvalid SHALL stay high until the imem_arready handshake; on the handshake -> R.
REQ-022 In R: imem_rready=1; on imem_rvalid -> inst<=imem_rdata, fetch_err[0]<=(imem_rresp!=2'b00), -> ISSUE.
REQ-023 In ISSUE: inst_valid=1 with inst, pc and fetch_err stable until inst_ready; on inst_ready -> WAIT_NPC.
REQ-024 In WAIT_NPC: on npc_valid -> pc<=npc, fetch_err<=0, -> AR.
REQ-025 npc_valid in any state other than WAIT_NPC SHALL be ignored and SHALL NOT change pc.
REQ-026 imem_rvalid outside R and imem_arready outside AR SHALL be ignored.
REQ-027 Latency: npc_valid at edge k -> imem_arvalid=1 after edge k+1; with zero-wait memory (arready in the same cycle, rvalid one cycle later), inst_valid=1 after edge k+3.
REQ-028 When arready and rvalid arrive back-to-back, no cycle SHALL be lost beyond one cycle per state.
REQ-029 pc SHALL change only in WAIT_NPC or on reset; no internal pc+4 increment is performed.

Reset
REQ-030 Reset (rst_n=0) SHALL force state=IDLE, pc=RESET_PC, inst=0, fetch_err=0, imem_arvalid=0, imem_rready=0 and inst_valid=0 immediately, independent of clk.
REQ-031 Reset mid-transaction SHALL abandon any outstanding read; memory is reset by the same rst_n.
REQ-032 After rst_n rises, the first imem_arvalid SHALL appear after the second rising edge, with address RESET_PC.

Structure
REQ-033 The state enum, RESET_PC default, RESP_OKAY constant and the NOP constant SHALL live in the shared CPU package.
REQ-034 The design SHALL be a single module with no sub-module; the FSM and datapath are too small to justify a split.

Verification
REQ-035 Reset release with zero-wait memory returning 32'h0010_0093 -> araddr=32'h8000_0000, then inst_valid with inst=32'h0010_0093, pc=32'h8000_0000, fetch_err=0.
REQ-036 arready held low for 5 cycles -> arvalid and araddr stable for all 5 cycles, with exactly one handshake.
REQ-037 WAIT_NPC with npc_valid and npc=32'h8000_0010 -> next araddr=32'h8000_0010; npc_valid pulsed during R -> pc unchanged.
REQ-038 npc=32'h8000_0006 -> no arvalid, inst_valid with inst=32'h0000_0013 and fetch_err=2'b10; imem_rresp=2'b10 -> fetch_err=2'b01.
REQ-039 inst_ready held low for 3 cycles -> inst_valid, inst and pc stable; rst_n low during R -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, reset PC, bus response
// codes and the instruction substituted when a fetch cannot be performed.
package ifu_fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_AR       = 3'd1,
      S_R        = 3'd2,
      S_ISSUE    = 3'd3,
      S_WAIT_NPC = 3'd4
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

   localparam logic [1:0]  ERR_NONE         = 2'b00;
   localparam logic [1:0]  ERR_BUS          = 2'b01;
   localparam logic [1:0]  ERR_MISALIGN     = 2'b10;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory read channel (address + data handshakes) between the
// fetch unit (master) and the memory (slave).
interface ifu_fetch_if;

   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  arvalid, araddr, rready,
      output arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches one word at the PC handed over by commit,
// offers it to decode, then waits for the next PC. No internal PC increment.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               npc_valid,
   input  logic [31:0]        npc,
   ifu_fetch_if.master        imem,
   output logic               inst_valid,
   output logic [31:0]        inst,
   output logic [31:0]        pc,
   input  logic               inst_ready,
   output logic [1:0]         fetch_err
);

   fetch_state_e state, state_nxt;
   logic         arvalid, arvalid_nxt;
   logic         rready, rready_nxt;
   logic         inst_valid_nxt;
   logic [31:0]  inst_nxt;
   logic [31:0]  pc_nxt;
   logic [1:0]   err_nxt;

   assign imem.arvalid = arvalid;
   assign imem.araddr  = pc;
   assign imem.rready  = rready;

   // The first AR cycle (arvalid still low) is the alignment check; the
   // request is only raised on the following edge.
   always_comb begin
      state_nxt      = state;
      arvalid_nxt    = arvalid;
      rready_nxt     = rready;
      inst_valid_nxt = inst_valid;
      inst_nxt       = inst;
      pc_nxt         = pc;
      err_nxt        = fetch_err;
      case (state)
         S_IDLE: state_nxt = S_AR;
         S_AR: begin
            if (!arvalid) begin
               if (pc[1:0] != 2'b00) begin
                  err_nxt        = ERR_MISALIGN;
                  inst_nxt       = NOP_INST;
                  inst_valid_nxt = 1'b1;
                  state_nxt      = S_ISSUE;
               end else begin
                  arvalid_nxt = 1'b1;
               end
            end else if (imem.arready) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = S_R;
            end
         end
         S_R: begin
            if (imem.rvalid) begin
               inst_nxt       = imem.rdata;
               err_nxt        = (imem.rresp != RESP_OKAY) ? ERR_BUS : ERR_NONE;
               rready_nxt     = 1'b0;
               inst_valid_nxt = 1'b1;
               state_nxt      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (inst_ready) begin
               inst_valid_nxt = 1'b0;
               state_nxt      = S_WAIT_NPC;
            end
         end
         S_WAIT_NPC: begin
            if (npc_valid) begin
               pc_nxt    = npc;
               err_nxt   = ERR_NONE;
               state_nxt = S_AR;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= '0;
         pc         <= RESET_PC;
         fetch_err  <= ERR_NONE;
      end else begin
         state      <= state_nxt;
         arvalid    <= arvalid_nxt;
         rready     <= rready_nxt;
         inst_valid <= inst_valid_nxt;
         inst       <= inst_nxt;
         pc         <= pc_nxt;
         fetch_err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a configurable-latency memory responder
// and a scoreboard of expected issued instructions.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        npc_valid;
   logic [31:0] npc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_ready;
   logic [1:0]  fetch_err;

   ifu_fetch_if imem_bus ();

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .npc_valid  (npc_valid),
      .npc        (npc),
      .imem       (imem_bus),
      .inst_valid (inst_valid),
      .inst       (inst),
      .pc         (pc),
      .inst_ready (inst_ready),
      .fetch_err  (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory responder: arready after ar_wait stalled cycles, rvalid r_wait
   // cycles after the address handshake
   int          ar_wait;
   int          r_wait;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   int          ar_cnt;
   int          r_cnt;
   logic        pending;
   int          ar_hs;
   int          ar_cyc;

   assign imem_bus.arready = imem_bus.arvalid && (ar_cnt >= ar_wait);
   assign imem_bus.rvalid  = pending && (r_cnt >= r_wait);
   assign imem_bus.rdata   = mem_rdata;
   assign imem_bus.rresp   = mem_rresp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_cnt  <= 0;
         r_cnt   <= 0;
         pending <= 1'b0;
         ar_hs   <= 0;
         ar_cyc  <= 0;
      end else begin
         if (imem_bus.arvalid) ar_cyc <= ar_cyc + 1;
         if (imem_bus.arvalid && imem_bus.arready) begin
            ar_cnt  <= 0;
            ar_hs   <= ar_hs + 1;
            pending <= 1'b1;
            r_cnt   <= 0;
         end else begin
            if (imem_bus.arvalid) ar_cnt <= ar_cnt + 1;
            if (pending && imem_bus.rvalid && imem_bus.rready) pending <= 1'b0;
            else if (pending && !imem_bus.rvalid) r_cnt <= r_cnt + 1;
         end
      end
   end

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  err;
   } exp_t;

   exp_t sb[$];
   int   n_assert;
   int   n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " arvalid"}, imem_bus.arvalid, 0);
      chk({tag, " rready"}, imem_bus.rready, 0);
      chk({tag, " inst_valid"}, inst_valid, 0);
      chk({tag, " pc"}, pc, RST_PC);
      chk({tag, " inst"}, inst, 0);
      chk({tag, " fetch_err"}, fetch_err, 0);
   endtask

   task automatic pulse_npc(input logic [31:0] a);
      npc_valid = 1'b1;
      npc       = a;
      @(negedge clk);
      npc_valid = 1'b0;
      npc       = '0;
   endtask

   // waits for inst_valid, checks it against the scoreboard head, optionally
   // stalls the decoder for 'hold' cycles, then accepts the instruction
   task automatic wait_inst(input string tag, input int hold, output int n);
      exp_t e;
      n = 0;
      while (!inst_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " inst_valid"}, inst_valid, 1);
      chk({tag, " sb_depth"}, sb.size(), 1);
      if (sb.size() > 0 && inst_valid) begin
         e = sb.pop_front();
         chk({tag, " inst"}, inst, e.inst);
         chk({tag, " pc"}, pc, e.pc);
         chk({tag, " fetch_err"}, fetch_err, e.err);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, inst_valid, 1);
            chk({tag, " hold inst"}, inst, e.inst);
            chk({tag, " hold pc"}, pc, e.pc);
         end
         inst_ready = 1'b1;
         @(negedge clk);
         inst_ready = 1'b0;
         chk({tag, " drop"}, inst_valid, 0);
      end
   endtask

   initial begin
      int n;
      int base;
      int cyc;
      n_assert   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      npc_valid  = 1'b0;
      npc        = '0;
      inst_ready = 1'b0;
      ar_wait    = 0;
      r_wait     = 0;
      mem_rdata  = 32'h0010_0093;
      mem_rresp  = 2'b00;

      #12;
      chk_reset("reset");

      // reset release, zero-wait fetch from RESET_PC, decoder stall of 3
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{inst: 32'h0010_0093, pc: RST_PC, err: 2'b00});
      @(negedge clk);
      chk("arvalid after edge1", imem_bus.arvalid, 0);
      @(negedge clk);
      chk("arvalid after edge2", imem_bus.arvalid, 1);
      chk("araddr first", imem_bus.araddr, RST_PC);
      wait_inst("boot", 3, n);
      chk("boot latency", n, 2);

      // arready stalled 5 cycles, npc pulse during R ignored
      ar_wait   = 5;
      r_wait    = 3;
      mem_rdata = 32'h0020_0113;
      base      = ar_hs;
      sb.push_back('{inst: 32'h0020_0113, pc: 32'h8000_0010, err: 2'b00});
      pulse_npc(32'h8000_0010);
      cyc = 0;
      n   = 0;
      while (!imem_bus.rready && n < 40) begin
         if (imem_bus.arvalid) begin
            cyc++;
            chk("ar stall addr", imem_bus.araddr, 32'h8000_0010);
         end
         @(negedge clk);
         n++;
      end
      chk("ar stall cycles", cyc, 6);
      chk("ar handshakes", ar_hs - base, 1);
      pulse_npc(32'hDEAD_BEE0);
      chk("pc in R", pc, 32'h8000_0010);
      chk("still in R", imem_bus.rready, 1);
      wait_inst("stall", 0, n);

      // zero-wait latency from npc_valid
      ar_wait   = 0;
      r_wait    = 0;
      mem_rdata = 32'h0030_0193;
      sb.push_back('{inst: 32'h0030_0193, pc: 32'h8000_0014, err: 2'b00});
      pulse_npc(32'h8000_0014);
      @(negedge clk);
      chk("lat arvalid", imem_bus.arvalid, 1);
      chk("lat araddr", imem_bus.araddr, 32'h8000_0014);
      wait_inst("zero wait", 0, n);
      chk("zero wait latency", n, 2);

      // misaligned PC never reaches the bus
      base = ar_cyc;
      sb.push_back('{inst: NOP_INST, pc: 32'h8000_0006, err: 2'b10});
      pulse_npc(32'h8000_0006);
      wait_inst("misalign", 0, n);
      chk("misalign no arvalid", ar_cyc - base, 0);

      // bus error response
      mem_rresp = 2'b10;
      mem_rdata = 32'h0040_0213;
      sb.push_back('{inst: 32'h0040_0213, pc: 32'h8000_0020, err: 2'b01});
      pulse_npc(32'h8000_0020);
      wait_inst("bus err", 0, n);
      chk("bus err latency", n, 3);
      mem_rresp = 2'b00;

      // reset asserted while waiting for read data
      r_wait = 5;
      pulse_npc(32'h8000_0030);
      n = 0;
      while (!imem_bus.rready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach R", imem_bus.rready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("mid reset");
      r_wait    = 0;
      mem_rdata = 32'h0050_0293;
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{inst: 32'h0050_0293, pc: RST_PC, err: 2'b00});
      wait_inst("reboot", 0, n);
      chk("reboot latency", n, 4);

      chk("sb drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
